cpu_trap_ctrl: RTL and testbench
================================

# cpu_trap_ctrl

Multi-cycle trap sequencer for the single-issue CPU core. It sits beside the branch/PC-select logic and turns synchronous exceptions, `mret` and (optionally) the external interrupt into a fixed sequence: stall the core, write `mepc`, `mcause` and `mstatus` over the shared CSR write port, then redirect the PC once. It owns the `mstatus.MIE`/`MPIE` bits and is the only block that ever redirects the PC to `mtvec` or `mepc`.

## Interface
Parameters:
- `XLEN`, default 32: data and address width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  an instruction is completing this cycle; all requests are qualified by it.
- `pc`  in  XLEN  PC of the completing instruction.
- `exc_misaligned`, `exc_illegal`, `exc_ebreak`, `exc_ecall`  in  1 each  exception flags from decode/fetch.
- `mret`  in  1  the completing instruction is `mret`.
- `irq_ext`  in  1  level external interrupt.
- `mtvec`, `mepc`  in  XLEN  current CSR values.
- `sw_mstatus_we`  in  1  a CSR instruction writes `mstatus`.
- `sw_mstatus_wdata`  in  XLEN  data for that write.
- `stall`  out  1  hold PC and pipeline registers.
- `flush`  out  1  suppress the register-file and memory writes of the completing instruction.
- `csr_we`  out  1  CSR write strobe.
- `csr_addr`  out  12  CSR write address.
- `csr_wdata`  out  XLEN  CSR write data.
- `redirect`  out  1  one-cycle PC override.
- `redirect_pc`  out  XLEN  target PC for that override.
- `mstatus_mie`, `mstatus_mpie`  out  1 each  current status bits.

## Operation
- States: `IDLE`, `SAVE_EPC`, `SAVE_CAUSE`, `SAVE_STATUS`, `RESTORE_STATUS`, `REDIRECT`.
- Request priority, evaluated in `IDLE` with `instr_valid=1`: misaligned > illegal > ebreak > ecall > `mret` > irq. An exception beats a simultaneous `mret`.
- Trap request:
  - Latch `pc` into `epc_q` and the cause into `cause_q`. Cause codes: misaligned 0, illegal 2, ebreak 3, ecall 11, irq `{1'b1, 27'b0, 4'd11}`.
  - Go to `SAVE_EPC`.
- Trap sequence:
  - `SAVE_EPC`: write 0x341 with `epc_q`.
  - `SAVE_CAUSE`: write 0x342 with `cause_q`.
  - `SAVE_STATUS`: write 0x300 with MPIE set to the old MIE and MIE cleared, all other bits 0. Update the internal bits the same way. Bit 3 is MIE, bit 7 is MPIE.
  - `REDIRECT`: `redirect=1`, `redirect_pc={mtvec[XLEN-1:2],2'b00}`. Direct mode only. Then return to `IDLE`.
- `mret` request:
  - Go to `RESTORE_STATUS`, which writes 0x300 with MIE set to MPIE and MPIE set to 1, updating the internal bits the same way.
  - Then `REDIRECT` with `redirect_pc=mepc` sampled in that cycle.
- Software `mstatus` write: `sw_mstatus_we` in `IDLE` loads MIE from bit 3 and MPIE from bit 7. It is ignored in every other state and when a request is accepted in the same cycle.
- Interrupt: taken only when `mstatus_mie=1`. The interrupted instruction is flushed and `mepc` is set to its `pc`.
- Requests arriving outside `IDLE` are ignored; the core is stalled during that time.

## Timing
- Reset: state `IDLE`, and all outputs are 0, including `mstatus_mie`, `mstatus_mpie`, `csr_addr` and `csr_wdata`. Reset mid-sequence abandons it, and no partial redirect occurs.
- Detect cycle (`IDLE` with an accepted request): `stall=1` and `flush=1`, both combinational.
- `stall` stays 1 through every state except `REDIRECT`. In `REDIRECT`, `stall=0` so the PC loads `redirect_pc` at the next edge.
- `csr_we` is asserted exactly one cycle per write state.
- Trap latency: redirect 4 cycles after the detect cycle. `mret` latency: 2 cycles.
- Back-to-back: a request is accepted in the first `IDLE` cycle after `REDIRECT`.
- `csr_addr` and `csr_wdata` are registered-state decodes with no combinational path from request inputs. `stall` and `flush` are the only outputs with a combinational path from the inputs.

## Configuration
- `CPU_TRAP_IRQ_EN` defined: `irq_ext` participates at the lowest priority, as described above.
- `CPU_TRAP_IRQ_EN` undefined: the port remains but is ignored, and the interrupt path and its cause code are compiled out. Exceptions and `mret` are unchanged.

## Structure
- Shared header `cpu_trap.vh`:
  - Cause codes.
  - CSR addresses `CSR_MSTATUS`, `CSR_MEPC`, `CSR_MCAUSE`.
  - `mstatus` bit positions.
  - State encoding.
- PC-source defines stay in `cpu_control.vh`.
- One sub-module, `cpu_trap_prio`: a combinational priority encoder producing `take`, `is_mret` and `cause`, so that the priority order is testable on its own.

## Test plan
- `exc_illegal` with `pc=0x100`, `mtvec=0x203`, MIE=1:
  - CSR writes in order: 0x341←0x100, 0x342←2, 0x300←0x80.
  - `redirect_pc=0x200` 4 cycles after detect.
  - MIE=0, MPIE=1 afterwards.
- `exc_ecall` and `mret` in the same cycle: trap with cause 11 is taken, and `mret` is dropped.
- `mret` with MPIE=1 and `mepc=0x440`: 0x300←0x88 in cycle 1, `redirect_pc=0x440` in cycle 2, MIE=1.
- `irq_ext=1`:
  - With MIE=0: no trap.
  - With MIE=1 and `CPU_TRAP_IRQ_EN`: `mcause=0x8000000B`, `mepc` equals the flushed `pc`.
  - With the macro undefined: no trap.
- Assert `rst` during `SAVE_CAUSE`: all outputs are 0 immediately, no `redirect`, and the next request runs a full sequence.
- `sw_mstatus_we` with data 0x08 in `IDLE`: MIE=1, MPIE=0. The same write during `SAVE_EPC` is ignored.

Source files
------------

// File: rtl/cpu_trap_pkg.sv
// Shared trap-controller definitions: cause codes, CSR addresses, mstatus bit positions, states.
// The external-interrupt cause only exists when CPU_TRAP_IRQ_EN is defined.
package cpu_trap_pkg;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK     = 4'd3;
  localparam logic [3:0] CAUSE_ECALL      = 4'd11;
`ifdef CPU_TRAP_IRQ_EN
  localparam logic [3:0] CAUSE_IRQ_EXT    = 4'd11;
`endif

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_STATUS,
    RESTORE_STATUS,
    REDIRECT
  } trap_state_e;

  // Low byte of an mstatus image holding only MIE and MPIE; all other bits are zero.
  function automatic logic [7:0] mstatus_byte(input logic mie, input logic mpie);
    logic [7:0] b;
    b = 8'h00;
    b[MSTATUS_MIE_BIT]  = mie;
    b[MSTATUS_MPIE_BIT] = mpie;
    return b;
  endfunction

endpackage

// File: rtl/cpu_trap_prio.sv
// Combinational request priority encoder: misaligned > illegal > ebreak > ecall > mret > irq.
// The irq leg exists only with CPU_TRAP_IRQ_EN defined.
module cpu_trap_prio
  import cpu_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            instr_valid,
  input  logic            exc_misaligned,
  input  logic            exc_illegal,
  input  logic            exc_ebreak,
  input  logic            exc_ecall,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            mie,
  output logic            take,
  output logic            is_mret,
  output logic [XLEN-1:0] cause
);

  always_comb begin
    take    = 1'b0;
    is_mret = 1'b0;
    cause   = '0;
    if (instr_valid) begin
      if (exc_misaligned) begin
        take       = 1'b1;
        cause[3:0] = CAUSE_MISALIGNED;
      end else if (exc_illegal) begin
        take       = 1'b1;
        cause[3:0] = CAUSE_ILLEGAL;
      end else if (exc_ebreak) begin
        take       = 1'b1;
        cause[3:0] = CAUSE_EBREAK;
      end else if (exc_ecall) begin
        take       = 1'b1;
        cause[3:0] = CAUSE_ECALL;
      end else if (mret) begin
        is_mret    = 1'b1;
`ifdef CPU_TRAP_IRQ_EN
      end else if (irq_ext && mie) begin
        take          = 1'b1;
        cause[3:0]    = CAUSE_IRQ_EXT;
        cause[XLEN-1] = 1'b1;
`endif
      end
    end
  end

`ifndef CPU_TRAP_IRQ_EN
  logic unused_irq;
  assign unused_irq = irq_ext & mie;
`endif

endmodule

// File: rtl/cpu_trap_ctrl.sv
// Trap sequencer: stalls the core, writes mepc/mcause/mstatus, then redirects the PC once.
// Define CPU_TRAP_IRQ_EN to let irq_ext raise a trap at the lowest priority.
module cpu_trap_ctrl
  import cpu_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            exc_misaligned,
  input  logic            exc_illegal,
  input  logic            exc_ebreak,
  input  logic            exc_ecall,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            sw_mstatus_we,
  input  logic [XLEN-1:0] sw_mstatus_wdata,
  output logic            stall,
  output logic            flush,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie,
  output logic            mstatus_mpie
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            is_trap_q, is_trap_d;

  logic            take;
  logic            is_mret;
  logic [XLEN-1:0] req_cause;

  cpu_trap_prio #(.XLEN(XLEN)) u_prio (
    .instr_valid    (instr_valid),
    .exc_misaligned (exc_misaligned),
    .exc_illegal    (exc_illegal),
    .exc_ebreak     (exc_ebreak),
    .exc_ecall      (exc_ecall),
    .mret           (mret),
    .irq_ext        (irq_ext),
    .mie            (mie_q),
    .take           (take),
    .is_mret        (is_mret),
    .cause          (req_cause)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      is_trap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      is_trap_q <= is_trap_d;
    end
  end

  // Only stall/flush and the IDLE transition look at request inputs; CSR outputs decode registered state.
  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    is_trap_d   = is_trap_q;
    stall       = 1'b1;
    flush       = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = 12'h000;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;

    unique case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (take) begin
          stall     = 1'b1;
          flush     = 1'b1;
          epc_d     = pc;
          cause_d   = req_cause;
          is_trap_d = 1'b1;
          state_d   = SAVE_EPC;
        end else if (is_mret) begin
          stall     = 1'b1;
          flush     = 1'b1;
          is_trap_d = 1'b0;
          state_d   = RESTORE_STATUS;
        end else if (sw_mstatus_we) begin
          mie_d  = sw_mstatus_wdata[MSTATUS_MIE_BIT];
          mpie_d = sw_mstatus_wdata[MSTATUS_MPIE_BIT];
        end
      end
      SAVE_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        csr_we         = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_wdata[7:0] = mstatus_byte(1'b0, mie_q);
        mpie_d         = mie_q;
        mie_d          = 1'b0;
        state_d        = REDIRECT;
      end
      RESTORE_STATUS: begin
        csr_we         = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_wdata[7:0] = mstatus_byte(mpie_q, 1'b1);
        mie_d          = mpie_q;
        mpie_d         = 1'b1;
        state_d        = REDIRECT;
      end
      REDIRECT: begin
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = is_trap_q ? {mtvec[XLEN-1:2], 2'b00} : mepc;
        state_d     = IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

  logic unused_bits;
  assign unused_bits = ^{mtvec[1:0], sw_mstatus_wdata};

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Scoreboard bench for cpu_trap_ctrl: stimulus pushes expected CSR writes / redirects,
// a negedge monitor pops and compares them, including the cycle they must appear in.
module tb_cpu_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic        exc_misaligned, exc_illegal, exc_ebreak, exc_ecall, mret, irq_ext;
  logic [31:0] mtvec, mepc;
  logic        sw_mstatus_we;
  logic [31:0] sw_mstatus_wdata;
  logic        stall, flush, csr_we, redirect, mstatus_mie, mstatus_mpie;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, redirect_pc;

  cpu_trap_ctrl #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .exc_misaligned   (exc_misaligned),
    .exc_illegal      (exc_illegal),
    .exc_ebreak       (exc_ebreak),
    .exc_ecall        (exc_ecall),
    .mret             (mret),
    .irq_ext          (irq_ext),
    .mtvec            (mtvec),
    .mepc             (mepc),
    .sw_mstatus_we    (sw_mstatus_we),
    .sw_mstatus_wdata (sw_mstatus_wdata),
    .stall            (stall),
    .flush            (flush),
    .csr_we           (csr_we),
    .csr_addr         (csr_addr),
    .csr_wdata        (csr_wdata),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .mstatus_mie      (mstatus_mie),
    .mstatus_mpie     (mstatus_mpie)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   det_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expCsr(input logic [11:0] addr, input logic [31:0] data, input int c);
    exp_t e;
    e.is_redir = 1'b0; e.addr = addr; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic expRedir(input logic [31:0] target, input int c);
    exp_t e;
    e.is_redir = 1'b1; e.addr = 12'h000; e.data = target; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic clearInputs();
    instr_valid = 0; pc = 0;
    exc_misaligned = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0;
    mret = 0; irq_ext = 0; sw_mstatus_we = 0; sw_mstatus_wdata = 0;
  endtask

  // Called #1 after a rising edge; drives one instruction for one cycle and returns #1 after the next edge.
  task automatic applyStimulus(input logic [31:0] pc_v, input logic mis, input logic ill,
                               input logic ebk, input logic ecl, input logic mr, input logic irq,
                               input logic swe, input logic [31:0] swd, input logic exp_accept);
    det_cyc = cyc;
    instr_valid = 1; pc = pc_v;
    exc_misaligned = mis; exc_illegal = ill; exc_ebreak = ebk; exc_ecall = ecl;
    mret = mr; irq_ext = irq; sw_mstatus_we = swe; sw_mstatus_wdata = swd;
    @(negedge clk);
    checkOutput("detect_stall", {31'b0, stall}, {31'b0, exp_accept});
    checkOutput("detect_flush", {31'b0, flush}, {31'b0, exp_accept});
    @(posedge clk); #1;
    clearInputs();
  endtask

  task automatic checkStatus(input string name, input logic mie, input logic mpie);
    checkOutput({name, "_mie"}, {31'b0, mstatus_mie}, {31'b0, mie});
    checkOutput({name, "_mpie"}, {31'b0, mstatus_mpie}, {31'b0, mpie});
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctl"}, {26'b0, stall, flush, csr_we, redirect, mstatus_mie, mstatus_mpie}, 32'h0);
    checkOutput({name, "_addr"}, {20'b0, csr_addr}, 32'h0);
    checkOutput({name, "_wdata"}, csr_wdata, 32'h0);
    checkOutput({name, "_rpc"}, redirect_pc, 32'h0);
  endtask

  // Monitor: every CSR write or redirect must match the head of the scoreboard, in the expected cycle.
  always @(negedge clk) begin
    if (!rst && (csr_we || redirect)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_event: got we=%0b redir=%0b addr=0x%0h data=0x%0h rpc=0x%0h expected none",
                 csr_we, redirect, csr_addr, csr_wdata, redirect_pc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ev_kind", {31'b0, redirect}, {31'b0, mon_e.is_redir});
        checkOutput("ev_cycle", cyc, mon_e.cyc);
        if (mon_e.is_redir) begin
          checkOutput("redirect_pc", redirect_pc, mon_e.data);
          checkOutput("redirect_stall", {31'b0, stall}, 32'h0);
        end else begin
          checkOutput("csr_addr", {20'b0, csr_addr}, {20'b0, mon_e.addr});
          checkOutput("csr_wdata", csr_wdata, mon_e.data);
          checkOutput("csr_stall", {31'b0, stall}, 32'h1);
        end
      end
    end
  end

  initial begin
    clearInputs();
    mtvec = 32'h203;
    mepc  = 32'h440;
    rst   = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 0;

    $display("[TB] software mstatus write in IDLE");
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 0);
    checkStatus("sw_write", 1, 0);

    $display("[TB] illegal instruction trap");
    applyStimulus(32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h100, det_cyc + 1);
    expCsr(12'h342, 32'h2, det_cyc + 2);
    expCsr(12'h300, 32'h80, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (4) @(posedge clk); #1;
    checkStatus("illegal", 0, 1);

    $display("[TB] mret");
    applyStimulus(32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    expCsr(12'h300, 32'h88, det_cyc + 1);
    expRedir(32'h440, det_cyc + 2);
    repeat (2) @(posedge clk); #1;
    checkStatus("mret", 1, 1);

    $display("[TB] ecall beats mret, same-cycle sw write dropped");
    applyStimulus(32'h200, 0, 0, 0, 1, 1, 0, 1, 32'h0, 1);
    expCsr(12'h341, 32'h200, det_cyc + 1);
    expCsr(12'h342, 32'hB, det_cyc + 2);
    expCsr(12'h300, 32'h80, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (4) @(posedge clk); #1;
    checkStatus("ecall", 0, 1);

    $display("[TB] irq with MIE=0");
    applyStimulus(32'h2F0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (4) @(posedge clk); #1;
    checkStatus("irq_masked", 0, 1);

    $display("[TB] irq with MIE=1");
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 0);
`ifdef CPU_TRAP_IRQ_EN
    applyStimulus(32'h300, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    expCsr(12'h341, 32'h300, det_cyc + 1);
    expCsr(12'h342, 32'h8000000B, det_cyc + 2);
    expCsr(12'h300, 32'h80, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (4) @(posedge clk); #1;
    checkStatus("irq_taken", 0, 1);
`else
    applyStimulus(32'h300, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (4) @(posedge clk); #1;
    checkStatus("irq_disabled", 1, 0);
`endif

    $display("[TB] sw write during SAVE_EPC ignored");
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0);
    checkStatus("sw_88", 1, 1);
    applyStimulus(32'h104, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h104, det_cyc + 1);
    expCsr(12'h342, 32'h0, det_cyc + 2);
    expCsr(12'h300, 32'h80, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    sw_mstatus_we = 1; sw_mstatus_wdata = 32'h0;
    @(posedge clk); #1;
    sw_mstatus_we = 0;
    repeat (3) @(posedge clk); #1;
    checkStatus("misaligned", 0, 1);

    $display("[TB] back-to-back ebreak then illegal");
    applyStimulus(32'h108, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h108, det_cyc + 1);
    expCsr(12'h342, 32'h3, det_cyc + 2);
    expCsr(12'h300, 32'h00, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (4) @(posedge clk); #1;
    applyStimulus(32'h10C, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h10C, det_cyc + 1);
    expCsr(12'h342, 32'h2, det_cyc + 2);
    expCsr(12'h300, 32'h00, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (4) @(posedge clk); #1;
    checkStatus("b2b", 0, 0);

    $display("[TB] reset during SAVE_CAUSE");
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 0);
    applyStimulus(32'h500, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h500, det_cyc + 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    repeat (6) @(posedge clk); #1;
    applyStimulus(32'h600, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    expCsr(12'h341, 32'h600, det_cyc + 1);
    expCsr(12'h342, 32'h2, det_cyc + 2);
    expCsr(12'h300, 32'h00, det_cyc + 3);
    expRedir(32'h200, det_cyc + 4);
    repeat (6) @(posedge clk); #1;
    checkStatus("post_reset", 0, 0);

    checkOutput("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
